// File: rtl/fpmul_rr_sequencer.sv
// Round-robin sequencer sharing one external combinational FP multiplier among NUM_REQ requesters.
// Define FPMUL_RR_SEQUENCER_FLAGS_EN to add the registered resp_flags (NaN/inf/zero) output.
module fpmul_rr_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic [ID_W-1:0]         resp_id
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
  ,
  output logic [2:0]              resp_flags
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d, tag_q, tag_d, ptr_q, ptr_d;
  logic            resp_valid_q, resp_valid_d;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;

  // Scan downward so the lowest offset from the pointer overwrites last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end
    end
  end

`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
  logic [2:0] flags_q, flags_d;
`endif

  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    tag_d        = tag_q;
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    req_ready    = '0;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
    flags_d      = flags_q;
`endif
    case (state_q)
      IDLE: begin
        // Suppress the accept during reset so no requester believes it was taken.
        if (gnt_any && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          mul_a_d = req_a[32*int'(gnt_idx) +: 32];
          mul_b_d = req_b[32*int'(gnt_idx) +: 32];
          tag_d   = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        resp_data_d  = mul_op;
        resp_id_d    = tag_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
        flags_d = {(mul_op[30:23] == 8'hFF) && (mul_op[22:0] != 23'd0),
                   (mul_op[30:23] == 8'hFF) && (mul_op[22:0] == 23'd0),
                   (mul_op[30:23] == 8'h00) && (mul_op[22:0] == 23'd0)};
`endif
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_q        <= '0;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_q        <= tag_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
  assign resp_flags = flags_q;
`endif

endmodule

// File: tb/tb_fpmul_rr_sequencer.sv
// Bench for fpmul_rr_sequencer: directed scenarios then random traffic checked against a
// transaction-level model (pending set, rotating pointer, one operation in flight).
module tb_fpmul_rr_sequencer;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [31:0]     mul_a, mul_b, mul_op;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [31:0]     resp_data;
  logic [1:0]      resp_id;
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
  logic [2:0]      resp_flags;
`endif

  always #5 clk = ~clk;

  fpmul_rr_sequencer #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id)
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
    , .resp_flags(resp_flags)
`endif
  );

  // Stand-in multiplier: exact for the directed operand pairs, an arbitrary mix otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h7F80_0000 && b == 32'h0000_0000) return 32'hFFC0_0000;
    if (a == 32'h0000_0000 && b == 32'h3F80_0000) return 32'h0000_0000;
    return (a * b) ^ {b[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  assign mul_op = fmul(mul_a, mul_b);

  int tests = 0, fails = 0;

  bit          pend[N];
  logic [31:0] pa[N], pb[N];
  int          ptr, cnt, exp_id, rr_mode;
  bit          busy, hold_all;
  logic [31:0] exp_a, exp_b, exp_d;
  int          glog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
  function automatic logic [2:0] class_of(input logic [31:0] d);
    int e; int f;
    e = int'(d[30:23]); f = int'(d[22:0]);
    return {e == 255 && f != 0, e == 255 && f == 0, e == 0 && f == 0};
  endfunction
`endif

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[32*i +: 32]  = pa[i];
      req_b[32*i +: 32]  = pb[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    int g; logic [N-1:0] er; bit out_v, xfer;
    drive();
    @(negedge clk);
    g = busy ? -1 : pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    out_v = busy && cnt >= 1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(out_v));
    if (busy) begin
      chk("mul_a", mul_a, exp_a);
      chk("mul_b", mul_b, exp_b);
    end
    if (out_v) begin
      chk("resp_data", resp_data, exp_d);
      chk("resp_id", 32'(resp_id), 32'(exp_id));
`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
      chk("resp_flags", 32'(resp_flags), 32'(class_of(exp_d)));
`endif
    end
    xfer = out_v && resp_ready;
    @(posedge clk); #1;
    if (g >= 0) begin
      busy = 1; cnt = 0; exp_id = g;
      exp_a = pa[g]; exp_b = pb[g]; exp_d = fmul(pa[g], pb[g]);
      ptr = (g + 1) % N;
      glog.push_back(g);
      if (hold_all) begin pa[g] = $urandom; pb[g] = $urandom; end
      else pend[g] = 0;
    end else if (busy) begin
      if (xfer) busy = 0; else cnt++;
    end
    if (rr_mode == 2) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    drive();
    repeat (ncyc) begin
      @(negedge clk);
      chk("req_ready_in_rst", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    busy = 0; ptr = 0; cnt = 0;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 0; pa[i] = $urandom; pb[i] = $urandom; end
    ptr = 0; cnt = 0; busy = 0; hold_all = 0; rr_mode = 0; exp_id = 0;
    exp_a = '0; exp_b = '0; exp_d = '0;
    do_reset(2);

    // single request, 2.0 * 3.0
    pa[0] = 32'h4000_0000; pb[0] = 32'h4040_0000; pend[0] = 1;
    run(4);
    chk("single_grant_count", 32'(glog.size()), 32'd1);

    // 1010 held continuously: grants 1,3,1
    do_reset(1); glog.delete(); hold_all = 1;
    pend[1] = 1; pend[3] = 1;
    run(9);
    hold_all = 0; clear_pend(); run(2);
    chk("alt_count", 32'(glog.size()), 32'd3);
    chk("alt_g0", 32'(glog[0]), 32'd1);
    chk("alt_g1", 32'(glog[1]), 32'd3);
    chk("alt_g2", 32'(glog[2]), 32'd1);

    // backpressure for five RESP cycles with another requester waiting
    resp_ready = 1'b0;
    pend[2] = 1; pa[2] = $urandom; pb[2] = $urandom;
    step();
    pend[0] = 1; pa[0] = $urandom; pb[0] = $urandom;
    run(6);
    resp_ready = 1'b1;
    run(6);

    // wrap-around with all four valid
    do_reset(1); glog.delete(); hold_all = 1;
    for (int i = 0; i < N; i++) pend[i] = 1;
    run(15);
    hold_all = 0; clear_pend(); run(3);
    chk("wrap_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("wrap_order", 32'(glog[i]), 32'(i % N));

    // reset while the granted operation is in CALC
    pend[2] = 1; pa[2] = $urandom; pb[2] = $urandom;
    step();
    do_reset(1);
    glog.delete();
    pend[1] = 1; pend[3] = 1;
    run(8);
    chk("post_rst_first", 32'(glog[0]), 32'd1);

`ifdef FPMUL_RR_SEQUENCER_FLAGS_EN
    pa[0] = 32'h7F80_0000; pb[0] = 32'h0000_0000; pend[0] = 1; run(4);
    pa[3] = 32'h0000_0000; pb[3] = 32'h3F80_0000; pend[3] = 1; run(4);
`endif

    // random traffic and random backpressure
    rr_mode = 2;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; pa[i] = $urandom; pb[i] = $urandom;
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
      end
      step();
    end
    rr_mode = 0; resp_ready = 1'b1; clear_pend();
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
